// File: rtl/pos_rx_deframer.sv
// Position receive deframer: hunts a SYNC_COUNT x SYNC_BYTE header, then assembles 10-bit X/Y from 4 payload bytes.
// Optional range rejection of X > X_MAX / Y > Y_MAX is enabled by defining POS_RX_RANGE_CHECK_EN.
module pos_rx_deframer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hFF,
    parameter int unsigned SYNC_COUNT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 60000,
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned Y_MAX          = 479
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [9:0] x_pos_out,
    output logic [9:0] y_pos_out,
    output logic       pos_valid,
    output logic       frame_err,
    output logic       sync_locked
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        X_LO = 3'd1,
        X_HI = 3'd2,
        Y_LO = 3'd3,
        Y_HI = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync_cnt_q, sync_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       x_lo_q, x_lo_d;
    logic [1:0]       x_hi_q, x_hi_d;
    logic [7:0]       y_lo_q, y_lo_d;
    logic [9:0]       x_pos_q, x_pos_d;
    logic [9:0]       y_pos_q, y_pos_d;
    logic             pos_valid_q, pos_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             locked_q, locked_d;
    logic             hi_bad;
    logic [9:0]       x_asm;
    logic [9:0]       y_asm;

`ifndef POS_RX_RANGE_CHECK_EN
    logic unused_range;
    assign unused_range = ^{10'(X_MAX), 10'(Y_MAX)};
`endif

    // Next-state, hold-register and output computation.
    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        tmo_d       = tmo_q;
        x_lo_d      = x_lo_q;
        x_hi_d      = x_hi_q;
        y_lo_d      = y_lo_q;
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        pos_valid_d = 1'b0;
        frame_err_d = 1'b0;
        locked_d    = locked_q;
        hi_bad      = |rx_data[7:2];
        x_asm       = {x_hi_q, x_lo_q};
        y_asm       = {rx_data[1:0], y_lo_q};

        if (rx_done) begin
            // A strobe always wins over a coincident timeout.
            tmo_d = '0;
            case (state_q)
                HUNT: begin
                    if (rx_data == SYNC_BYTE) begin
                        if (sync_cnt_q >= 4'(SYNC_COUNT - 1)) begin
                            sync_cnt_d = 4'd0;
                            state_d    = X_LO;
                        end else begin
                            sync_cnt_d = sync_cnt_q + 4'd1;
                        end
                    end else begin
                        sync_cnt_d = 4'd0;
                    end
                end
                X_LO: begin
                    x_lo_d  = rx_data;
                    state_d = X_HI;
                end
                X_HI: begin
                    if (hi_bad) begin
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                        state_d     = HUNT;
                    end else begin
                        x_hi_d  = rx_data[1:0];
                        state_d = Y_LO;
                    end
                end
                Y_LO: begin
                    y_lo_d  = rx_data;
                    state_d = Y_HI;
                end
                Y_HI: begin
                    state_d = HUNT;
                    if (hi_bad) begin
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
`ifdef POS_RX_RANGE_CHECK_EN
                    end else if ((x_asm > 10'(X_MAX)) || (y_asm > 10'(Y_MAX))) begin
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
`endif
                    end else begin
                        x_pos_d     = x_asm;
                        y_pos_d     = y_asm;
                        pos_valid_d = 1'b1;
                        locked_d    = 1'b1;
                    end
                end
                default: begin
                    state_d    = HUNT;
                    sync_cnt_d = 4'd0;
                end
            endcase
        end else begin
            if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
                tmo_d = tmo_q + TMO_W'(1);
            end else begin
                tmo_d = tmo_q;
            end
            // Act only on the cycle the counter reaches the limit, not while saturated.
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                if (state_q != HUNT) begin
                    frame_err_d = 1'b1;
                    locked_d    = 1'b0;
                    state_d     = HUNT;
                    sync_cnt_d  = 4'd0;
                end else if (sync_cnt_q != 4'd0) begin
                    locked_d   = 1'b0;
                    sync_cnt_d = 4'd0;
                end else begin
                    locked_d = locked_q;
                end
            end else begin
                state_d = state_q;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            sync_cnt_q  <= 4'd0;
            tmo_q       <= '0;
            x_lo_q      <= 8'd0;
            x_hi_q      <= 2'd0;
            y_lo_q      <= 8'd0;
            x_pos_q     <= 10'd0;
            y_pos_q     <= 10'd0;
            pos_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            tmo_q       <= tmo_d;
            x_lo_q      <= x_lo_d;
            x_hi_q      <= x_hi_d;
            y_lo_q      <= y_lo_d;
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
            pos_valid_q <= pos_valid_d;
            frame_err_q <= frame_err_d;
            locked_q    <= locked_d;
        end
    end

    assign x_pos_out   = x_pos_q;
    assign y_pos_out   = y_pos_q;
    assign pos_valid   = pos_valid_q;
    assign frame_err   = frame_err_q;
    assign sync_locked = locked_q;

endmodule

// File: tb/tb_pos_rx_deframer.sv
// Directed self-checking bench for pos_rx_deframer; outputs are sampled on the falling clock edge.
module tb_pos_rx_deframer;

    localparam int unsigned TMO = 300;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [9:0] x_pos_out;
    logic [9:0] y_pos_out;
    logic       pos_valid;
    logic       frame_err;
    logic       sync_locked;

    int n_pass  = 0;
    int n_total = 0;
    logic early;
    logic seen;

    pos_rx_deframer #(
        .SYNC_BYTE      (8'hFF),
        .SYNC_COUNT     (4),
        .TIMEOUT_CYCLES (TMO),
        .X_MAX          (639),
        .Y_MAX          (479)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .x_pos_out   (x_pos_out),
        .y_pos_out   (y_pos_out),
        .pos_valid   (pos_valid),
        .frame_err   (frame_err),
        .sync_locked (sync_locked)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Sends n bytes of v (first byte in the most significant position), gap idle cycles between strobes.
    // Returns at the falling edge right after the last strobe was clocked; flags any pulse seen before then.
    task automatic send_seq(input logic [95:0] v, input int n, input int gap);
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_data = v[8*(n-1-i) +: 8];
            rx_done = 1'b1;
            @(negedge clk);
            rx_done = 1'b0;
            if (i < n - 1) begin
                early = early | pos_valid | frame_err;
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    early = early | pos_valid | frame_err;
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        rx_data = 8'd0;
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x", x_pos_out, 0);
        check("rst_y", y_pos_out, 0);
        check("rst_valid", pos_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_lock", sync_locked, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, 20 cycles between strobes.
        send_seq(96'hFFFFFFFF2C01DF01, 8, 20);
        check("f1_early", early, 0);
        check("f1_x", x_pos_out, 300);
        check("f1_y", y_pos_out, 479);
        check("f1_valid", pos_valid, 1);
        check("f1_lock", sync_locked, 1);
        @(negedge clk);
        check("f1_valid_pulse", pos_valid, 0);

        // 0xFF as X low byte; X=1023 exceeds X_MAX.
        send_seq(96'hFFFFFFFFFF030000, 8, 3);
`ifdef POS_RX_RANGE_CHECK_EN
        check("f2_err", frame_err, 1);
        check("f2_valid", pos_valid, 0);
        check("f2_x", x_pos_out, 300);
        check("f2_y", y_pos_out, 479);
        check("f2_lock", sync_locked, 0);
`else
        check("f2_err", frame_err, 0);
        check("f2_valid", pos_valid, 1);
        check("f2_x", x_pos_out, 1023);
        check("f2_y", y_pos_out, 0);
        check("f2_lock", sync_locked, 1);
`endif

        // Bad X high byte.
        send_seq(96'hFFFFFFFF1005, 6, 2);
        check("f3_early", early, 0);
        check("f3_err", frame_err, 1);
        check("f3_valid", pos_valid, 0);
        check("f3_lock", sync_locked, 0);
        send_seq(96'hFFFFFFFF0A001400, 8, 1);
        check("f3b_x", x_pos_out, 10);
        check("f3b_y", y_pos_out, 20);
        check("f3b_valid", pos_valid, 1);
        check("f3b_lock", sync_locked, 1);

        // Header interrupted by 00; strobe held high for all bytes.
        send_seq(96'hFFFF00FFFFFFFF01000200, 11, 0);
        check("f4_early", early, 0);
        check("f4_x", x_pos_out, 1);
        check("f4_y", y_pos_out, 2);
        check("f4_valid", pos_valid, 1);

        // Mid-frame timeout in Y_LO.
        send_seq(96'hFFFFFFFF0B00, 6, 2);
        seen = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            @(negedge clk);
            seen = seen | frame_err;
        end
        check("tmo_early_err", seen, 0);
        @(negedge clk);
        check("tmo_err", frame_err, 1);
        check("tmo_x", x_pos_out, 1);
        check("tmo_y", y_pos_out, 2);
        check("tmo_lock", sync_locked, 0);
        check("tmo_valid", pos_valid, 0);
        @(negedge clk);
        check("tmo_err_pulse", frame_err, 0);
        send_seq(96'hFFFFFFFF03000400, 8, 2);
        check("tmo_next_x", x_pos_out, 3);
        check("tmo_next_y", y_pos_out, 4);
        check("tmo_next_valid", pos_valid, 1);

        // Partial header timeout in HUNT clears sync count without frame_err.
        send_seq(96'hFFFF, 2, 1);
        seen = 1'b0;
        for (int k = 0; k < TMO + 5; k++) begin
            @(negedge clk);
            seen = seen | frame_err;
        end
        check("hunt_tmo_err", seen, 0);
        check("hunt_tmo_lock", sync_locked, 0);
        send_seq(96'hFFFFFFFF07000800, 8, 1);
        check("hunt_next_x", x_pos_out, 7);
        check("hunt_next_y", y_pos_out, 8);
        check("hunt_next_valid", pos_valid, 1);

        // Reset after X_HI discards the partial frame.
        send_seq(96'hFFFFFFFF0900, 6, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_x", x_pos_out, 0);
        check("mrst_y", y_pos_out, 0);
        check("mrst_lock", sync_locked, 0);
        rst = 1'b0;
        @(negedge clk);
        send_seq(96'hFFFFFFFF05000600, 8, 1);
        check("mrst_early", early, 0);
        check("mrst_next_x", x_pos_out, 5);
        check("mrst_next_y", y_pos_out, 6);
        check("mrst_next_valid", pos_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pos_rx_deframer.md
Name: pos_rx_deframer

Overview:
Receive-side counterpart of the position transmit packetizer. Consumes bytes from the UART receiver (data plus one-cycle done strobe) and hunts for the sync header of SYNC_COUNT consecutive 0xFF bytes. It then reassembles the 4-byte payload {X[7:0], X[9:8], Y[7:0], Y[9:8]} into 10-bit X/Y positions. It sits between the UART RX core and the remote-player position logic, and presents X/Y as an atomic pair with a valid pulse.

Parameters:
SYNC_BYTE, 8'hFF, value of each header byte
SYNC_COUNT, 4, number of consecutive SYNC_BYTE bytes forming the header (range 2..15)
TIMEOUT_CYCLES, 60000, max clk cycles between rx_done strobes inside a frame before the frame is abandoned
X_MAX, 639, largest legal X (used only with the optional feature)
Y_MAX, 479, largest legal Y (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  reset
rx_data  input  8  received byte, valid when rx_done=1
rx_done  input  1  one-cycle strobe from UART RX, one byte per strobe
x_pos_out  output  10  last accepted X position
y_pos_out  output  10  last accepted Y position
pos_valid  output  1  one-cycle pulse: x/y_pos_out updated this cycle
frame_err  output  1  one-cycle pulse: frame discarded (bad high byte, timeout, range)
sync_locked  output  1  high after a good frame, low after any error or reset

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: x_pos_out=0, y_pos_out=0, pos_valid=0, frame_err=0, sync_locked=0. State=HUNT, sync_cnt=0, timeout counter=0, hold registers=0.
- FSM states: HUNT, X_LO, X_HI, Y_LO, Y_HI. All transitions occur only on cycles with rx_done=1, except timeout.
- HUNT: rx_data==SYNC_BYTE -> sync_cnt+1 (saturating). Any other byte -> sync_cnt=0. When the strobe makes sync_cnt reach SYNC_COUNT, go to X_LO and clear sync_cnt.
- X_LO: store the byte unconditionally, including 0xFF (a legal X low byte). Go to X_HI.
- X_HI: if rx_data[7:2]!=0 -> frame_err pulse, sync_locked=0, go to HUNT. Otherwise store bits [1:0] and go to Y_LO.
- Y_LO: store the byte unconditionally. Go to Y_HI.
- Y_HI: apply the same [7:2] check as X_HI. On pass, load x_pos_out and y_pos_out from the hold registers in the same clock edge. pos_valid=1 for exactly one cycle, sync_locked=1, go to HUNT.
- Latency: outputs and pulses are registered and appear on the cycle after the Y_HI rx_done cycle.
- Outputs are never partially updated. X and Y change together or not at all.
- Timeout counter: clears on every rx_done and counts otherwise, saturating at TIMEOUT_CYCLES. On reaching TIMEOUT_CYCLES in any non-HUNT state, or in HUNT with sync_cnt>0: frame_err pulse (non-HUNT only), sync_locked=0, state=HUNT, sync_cnt=0.
- Simultaneous rx_done and timeout on the same cycle: rx_done wins; the byte is processed and the counter clears.
- Extra 0xFF bytes beyond SYNC_COUNT in HUNT: not possible by construction, since state leaves HUNT at the count. A fifth 0xFF becomes X_LO.
- rst mid-frame: partial frame discarded, all outputs and state return to reset values next cycle.
- rx_done held high across consecutive cycles: each cycle counts as a separate byte.

Optional Feature:
POS_RX_RANGE_CHECK_EN.
- Defined: at Y_HI pass, if assembled X>X_MAX or Y>Y_MAX -> frame_err pulse, sync_locked=0, outputs unchanged, no pos_valid, go to HUNT.
- Undefined: no range comparison; any 10-bit value is accepted, and X_MAX/Y_MAX are unused.

Test Plan:
- Bytes FF FF FF FF 2C 01 DF 01, 20 cycles apart -> one cycle after the last strobe: x_pos_out=300, y_pos_out=479, pos_valid single pulse, sync_locked=1.
- Bytes FF FF FF FF FF 03 00 00 -> x_pos_out=1023, y_pos_out=0, pos_valid pulse with macro undefined. With POS_RX_RANGE_CHECK_EN: frame_err pulse, outputs keep their previous values.
- Bytes FF FF FF FF 10 05 ... -> frame_err on the 0x05 byte, sync_locked=0. Following good frame FF FF FF FF 0A 00 14 00 -> x=10, y=20.
- Bytes FF FF 00 FF FF FF FF 01 00 02 00 -> header restarts at 00; frame accepted with x=1, y=2.
- Header plus 2 payload bytes, then no strobe for TIMEOUT_CYCLES -> frame_err pulse exactly at timeout, state HUNT, outputs unchanged. Next full frame accepted.
- rst asserted after X_HI, then frame FF FF FF FF 05 00 06 00 -> outputs 0 during reset, then x=5, y=6; no stale bytes used.
